// File: rtl/ram_sparc_sync.sv
// ram_sparc_sync: clocked big-endian byte memory with MFA/MFC handshake, wait states,
// double-word transfers and alignment checking for the SPARC datapath.
module ram_sparc_sync #(
  parameter int ADDR_WIDTH = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MFA,
  input  logic [5:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MFC,
  output logic                  MisAlign
);
  localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [2:0] {IDLE, WAIT1, ACC1, MID, WAIT2, ACC2, DONE} state_t;
  state_t st, nxt;
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [5:0] op;
  logic [ADDR_WIDTH-1:0] addr, a0, a1, a2, a3;
  logic [31:0] din, word, ld_val;
  logic [CW-1:0] cnt;
  logic sz_b, sz_h, sz_w, sz_d, is_st, is_ld, mis, acc;
  assign sz_b = op inside {6'b001001, 6'b000001, 6'b000101};
  assign sz_h = op inside {6'b001010, 6'b000010, 6'b000110};
  assign sz_w = op inside {6'b001000, 6'b000100};
  assign sz_d = op inside {6'b000011, 6'b000111};
  assign is_st = op inside {6'b000101, 6'b000110, 6'b000100, 6'b000111};
  assign is_ld = (sz_b | sz_h | sz_w | sz_d) & ~is_st;
  assign mis = (sz_h & addr[0]) | (sz_w & |addr[1:0]) | (sz_d & |addr[2:0]);
  assign acc = (st == ACC1 || st == ACC2) && !mis;
  assign a0 = st == ACC2 ? addr + ADDR_WIDTH'(4) : addr;
  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);
  // byte and halfword loads come from the top of the big-endian word at a0
  assign word = {mem[a0], mem[a1], mem[a2], mem[a3]};
  assign ld_val = op == 6'b001001 ? {{24{word[31]}}, word[31:24]} :
                  op == 6'b000001 ? {24'd0, word[31:24]} :
                  op == 6'b001010 ? {{16{word[31]}}, word[31:16]} :
                  op == 6'b000010 ? {16'd0, word[31:16]} : word;
  assign MFC = st == MID || st == DONE;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = MFA ? (WAIT_STATES == 0 ? ACC1 : WAIT1) : IDLE;
      WAIT1:   nxt = cnt == LAST ? ACC1 : WAIT1;
      ACC1:    nxt = sz_d && !mis ? MID : DONE;
      MID:     nxt = WAIT_STATES == 0 ? ACC2 : WAIT2;
      WAIT2:   nxt = cnt == LAST ? ACC2 : WAIT2;
      ACC2:    nxt = DONE;
      DONE:    nxt = MFA ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      op <= '0;
      addr <= '0;
      din <= '0;
      DataOut <= '0;
      MisAlign <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= (st == WAIT1 || st == WAIT2) && cnt != LAST ? cnt + 1'b1 : '0;
      if (st == IDLE && MFA) begin
        op <= opcode;
        addr <= address;
        din <= DataIn;
        MisAlign <= 1'b0;
      end
      if (st == MID) din <= DataIn;
      if (st == ACC1) MisAlign <= mis;
      if (acc && is_ld) DataOut <= ld_val;
    end
  // memory contents survive reset; each word lands on a single edge
  always_ff @(posedge clk)
    if (acc && is_st) begin
      mem[a0] <= sz_b ? din[7:0] : sz_h ? din[15:8] : din[31:24];
      if (!sz_b) mem[a1] <= sz_h ? din[7:0] : din[23:16];
      if (sz_w | sz_d) begin
        mem[a2] <= din[15:8];
        mem[a3] <= din[7:0];
      end
    end
endmodule

// File: tb/tb_ram_sparc_sync.sv
// tb_ram_sparc_sync: three DUTs (W=1,0,3) checked each cycle against a byte-array model
// whose output timeline follows the handshake latency rules.
module tb_ram_sparc_sync;
  logic clk = 1'b0, reset;
  logic mfa [3];
  logic [5:0] opc [3];
  logic [7:0] adr [3];
  logic [31:0] din [3], dout [3], e_dout [3];
  logic mfc [3], mis [3], e_mfc [3], e_mis [3];
  logic [7:0] m [3][256];
  logic [5:0] ops [11] = '{6'h09, 6'h0A, 6'h08, 6'h01, 6'h02, 6'h03, 6'h05, 6'h06, 6'h04, 6'h07, 6'h2A};
  logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_sparc_sync #(.ADDR_WIDTH(8), .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : 3)) dut (
      .clk(clk), .reset(reset), .MFA(mfa[g]), .opcode(opc[g]), .address(adr[g]),
      .DataIn(din[g]), .DataOut(dout[g]), .MFC(mfc[g]), .MisAlign(mis[g]));
  end
  function automatic int ws(int k);
    return k == 0 ? 1 : k == 1 ? 0 : 3;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (chk_en)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("mfc%0d", k), 32'(mfc[k]), 32'(e_mfc[k]));
        check($sformatf("dout%0d", k), dout[k], e_dout[k]);
        check($sformatf("misalign%0d", k), 32'(mis[k]), 32'(e_mis[k]));
      end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // move n bytes between the model array and the expected DataOut
  task automatic xfer(int k, logic [7:0] a, int n, bit ld, bit sgn, logic [31:0] d);
    logic [31:0] v;
    logic [7:0] p;
    v = 0;
    for (int i = 0; i < n; i++) begin
      p = a + 8'(i);
      if (ld) v = (v << 8) | 32'(m[k][p]);
      else m[k][p] = 8'(d >> (8 * (n - 1 - i)));
    end
    if (ld && sgn && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
    if (ld) e_dout[k] = v;
  endtask
  task automatic req(int k, logic [5:0] op, logic [7:0] a, logic [31:0] d0, logic [31:0] d1, int hold, bit drop);
    int w, sz;
    bit ld, bad;
    w = ws(k);
    sz = (op inside {6'h01, 6'h09, 6'h05}) ? 1 : (op inside {6'h02, 6'h0A, 6'h06}) ? 2 :
         (op inside {6'h04, 6'h08}) ? 4 : (op inside {6'h03, 6'h07}) ? 8 : 0;
    ld = op inside {6'h01, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0A};
    bad = sz > 1 && (int'(a) % sz) != 0;
    mfa[k] = 1; opc[k] = op; adr[k] = a; din[k] = d0;
    step();
    e_mfc[k] = 0; e_mis[k] = 0;
    if (drop) mfa[k] = 0;
    repeat (w) step();
    step();
    e_mfc[k] = 1; e_mis[k] = bad;
    if (sz != 0 && !bad) begin
      xfer(k, a, sz == 8 ? 4 : sz, ld, op inside {6'h09, 6'h0A}, d0);
      if (sz == 8) begin
        din[k] = d1;
        step();
        e_mfc[k] = 0;
        repeat (w) step();
        step();
        e_mfc[k] = 1;
        xfer(k, a + 8'd4, 4, ld, 0, d1);
      end
    end
    if (!drop) begin
      repeat (hold) step();
      mfa[k] = 0;
    end
    step();
    e_mfc[k] = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] old;
    logic [7:0] a;
    logic [5:0] op;
    reset = 1;
    for (int k = 0; k < 3; k++) begin
      mfa[k] = 0; opc[k] = 0; adr[k] = 0; din[k] = 0;
      e_dout[k] = 0; e_mfc[k] = 0; e_mis[k] = 0;
    end
    step(); step();
    for (int k = 0; k < 3; k++) begin
      check("rst_dout", dout[k], 32'h0);
      check("rst_mfc", 32'(mfc[k]), 32'h0);
      check("rst_mis", 32'(mis[k]), 32'h0);
    end
    reset = 0;
    chk_en = 1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) req(k, 6'h04, 8'(i * 4), $urandom, 0, 0, 0);
    req(0, 6'h04, 8'h10, 32'hDEADBEEF, 0, 0, 0);
    req(0, 6'h08, 8'h10, 0, 0, 0, 0);
    check("ld_10", dout[0], 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      req(0, 6'h01, 8'h10 + 8'(i), 0, 0, 0, 0);
      check("byte_1x", dout[0], 32'(exp_b[i]));
    end
    req(0, 6'h05, 8'h21, 32'h80, 0, 0, 0);
    req(0, 6'h06, 8'h22, 32'h8001, 0, 0, 0);
    req(0, 6'h09, 8'h21, 0, 0, 0, 0); check("ldsb", dout[0], 32'hFFFFFF80);
    req(0, 6'h01, 8'h21, 0, 0, 0, 0); check("ldub", dout[0], 32'h00000080);
    req(0, 6'h0A, 8'h22, 0, 0, 0, 0); check("ldsh", dout[0], 32'hFFFF8001);
    req(0, 6'h02, 8'h22, 0, 0, 0, 0); check("lduh", dout[0], 32'h00008001);
    req(0, 6'h07, 8'h40, 32'h11111111, 32'h22222222, 1, 0);
    req(0, 6'h03, 8'h40, 0, 0, 2, 0); check("ldd_w1", dout[0], 32'h22222222);
    req(0, 6'h08, 8'h44, 0, 0, 0, 0); check("ld_44", dout[0], 32'h22222222);
    req(0, 6'h08, 8'h40, 0, 0, 0, 0); check("ld_40", dout[0], 32'h11111111);
    req(0, 6'h04, 8'h41, 32'hCAFEF00D, 0, 0, 0); check("mis_st", 32'(mis[0]), 32'h1);
    req(0, 6'h06, 8'h43, 32'hCAFEF00D, 0, 0, 0); check("mis_sth", 32'(mis[0]), 32'h1);
    req(0, 6'h03, 8'h44, 0, 0, 0, 0); check("mis_ldd", 32'(mis[0]), 32'h1);
    check("mis_dout", dout[0], 32'h11111111);
    req(0, 6'h08, 8'h44, 0, 0, 0, 0); check("mis_mem44", dout[0], 32'h22222222);
    req(0, 6'h08, 8'h40, 0, 0, 0, 0); check("mis_mem40", dout[0], 32'h11111111);
    req(0, 6'h2A, 8'h40, 32'h5, 0, 0, 0); check("unk_mis", 32'(mis[0]), 32'h0);
    check("unk_dout", dout[0], 32'h11111111);
    for (int k = 1; k < 3; k++) begin
      req(k, 6'h04, 8'h30, 32'hA5A55A5A, 0, 5, 0);
      req(k, 6'h08, 8'h30, 0, 0, 5, 0);
      check("lat_ld", dout[k], 32'hA5A55A5A);
      req(k, 6'h08, 8'h30, 0, 0, 0, 1);
      req(k, 6'h07, 8'h48, 32'h33333333, 32'h44444444, 0, 1);
      req(k, 6'h03, 8'h48, 0, 0, 5, 0);
      check("lat_ldd", dout[k], 32'h44444444);
    end
    old = {m[0][8'h84], m[0][8'h85], m[0][8'h86], m[0][8'h87]};
    mfa[0] = 1; opc[0] = 6'h07; adr[0] = 8'h80; din[0] = 32'h76543210;
    step();
    e_mfc[0] = 0; e_mis[0] = 0;
    step();
    step();
    e_mfc[0] = 1;
    xfer(0, 8'h80, 4, 0, 0, 32'h76543210);
    din[0] = 32'hFEDCBA98;
    step();
    e_mfc[0] = 0;
    reset = 1;
    mfa[0] = 0;
    for (int k = 0; k < 3; k++) begin e_dout[k] = 0; e_mfc[k] = 0; e_mis[k] = 0; end
    #1;
    check("rst_mid_dout", dout[0], 32'h0);
    check("rst_mid_mfc", 32'(mfc[0]), 32'h0);
    step();
    reset = 0;
    req(0, 6'h08, 8'h80, 0, 0, 0, 0); check("rst_w0", dout[0], 32'h76543210);
    req(0, 6'h08, 8'h84, 0, 0, 0, 0); check("rst_w1", dout[0], old);
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 10)];
      a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a = a & 8'hF8;
      req($urandom_range(0, 2), op, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 4) == 0);
    end
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_sparc_sync.md
# ram_sparc_sync

Clocked, parametrised byte-addressed data memory for the SPARC datapath, replacing the untimed behavioural RAM. It keeps the MFA/MFC handshake and the SPARC load/store opcode encoding. It adds configurable depth, configurable wait states, working `ldd`/`std` double-word transfers, and alignment checking. The block sits between the control unit's memory interface (MAR, MDR, MFA) and the rest of the datapath.

## Interface
- `ADDR_WIDTH`, default 8: byte address width; depth is 2^ADDR_WIDTH bytes.
- `WAIT_STATES`, default 1: extra cycles inserted before each word access; 0 is legal.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `MFA`, input, 1: memory function active (request).
- `opcode`, input, 6: SPARC op3 load/store code.
- `address`, input, ADDR_WIDTH: byte address of the first byte.
- `DataIn`, input, 32: store data.
- `DataOut`, output, 32: load data, registered.
- `MFC`, output, 1: memory function complete.
- `MisAlign`, output, 1: access rejected as misaligned; valid while MFC=1.

## Operation
- Memory is an array of 2^ADDR_WIDTH bytes, big-endian: the byte at `address` is the most significant byte. Contents are not reset.
- Opcodes:
  - 001001 `ldsb`: sign-extend the byte.
  - 001010 `ldsh`: sign-extend from bit 7 of the byte at `address`.
  - 001000 `ld`: load word.
  - 000001 `ldub`: zero-extend the byte.
  - 000010 `lduh`: zero-extend the halfword.
  - 000011 `ldd`: two words, at `address` then `address+4`.
  - 000101 `stb`: write DataIn[7:0].
  - 000110 `sth`: write DataIn[15:0].
  - 000100 `st`: write DataIn[31:0].
  - 000111 `std`: two words.
- Alignment rules:
  - Halfword requires address[0]=0.
  - Word requires address[1:0]=0.
  - Double requires address[2:0]=0.
  - A misaligned access does not touch memory and leaves DataOut unchanged. It completes with MFC=1 and MisAlign=1, with the same latency as a normal access.
- Aligned accesses never cross the top of memory. Address arithmetic is modulo 2^ADDR_WIDTH.
- An unknown opcode completes normally (MFC=1, MisAlign=0), with no memory change and DataOut unchanged.
- State machine:
  - IDLE: on MFA=1, latch opcode, address and DataIn, then go to WAIT1 (or ACC1 if WAIT_STATES=0).
  - WAIT1: count WAIT_STATES cycles, then go to ACC1.
  - ACC1: perform the word-0 access. Double ops go to MID; all others go to DONE.
  - MID: MFC=1 for exactly one cycle with word 0 on DataOut. For `std`, DataIn is sampled as word 1 at the edge leaving MID. Go to WAIT2 or ACC2.
  - WAIT2: count WAIT_STATES cycles, then go to ACC2.
  - ACC2: access `address+4`, then go to DONE.
  - DONE: hold MFC=1. Go to IDLE on the edge that samples MFA=0.
- MFA is ignored from acceptance until DONE. Dropping MFA mid-operation never aborts it.
- MisAlign is cleared when a new request is accepted.

## Timing
- Reset values: DataOut=0, MFC=0, MisAlign=0, state IDLE. Reset asserted mid-operation returns to IDLE immediately.
- Reset and writes:
  - Each word is written in a single edge, so a word is either fully written or not at all.
  - A reset during `std` after MID leaves word 0 written and word 1 not written.
- Let E0 be the edge that accepts MFA and W = WAIT_STATES.
- Single-word op:
  - DataOut is valid and MFC rises after edge E0+W+1.
  - MFC falls after the first edge in DONE that samples MFA=0.
- Double op:
  - MFC is high for the one cycle after E0+W+1, carrying word 0.
  - MFC is low after E0+W+2.
  - MFC is high again after E0+2W+3 with word 1, held until MFA=0.
- Back-to-back requests: MFA must be sampled low at least once, through DONE→IDLE. The next request is accepted on an edge in IDLE, so the minimum gap is one IDLE cycle.

## Test plan
- Store then load, with W=1:
  - Stimulus: `st` 0xDEADBEEF @0x10, then `ld` @0x10.
  - Response: DataOut=0xDEADBEEF. MFC rises 2 cycles after acceptance. Bytes 0x10..0x13 = DE, AD, BE, EF.
- Sign and zero extension, after `stb` 0x80 @0x21 and `sth` 0x8001 @0x22:
  - `ldsb` @0x21 → 0xFFFFFF80.
  - `ldub` @0x21 → 0x00000080.
  - `ldsh` @0x22 → 0xFFFF8001.
  - `lduh` @0x22 → 0x00008001.
- Double word:
  - Stimulus: `std` 0x11111111 then 0x22222222 @0x40, followed by `ldd` @0x40.
  - Response: a one-cycle MFC pulse with 0x11111111, then MFC held with 0x22222222. A `ld` @0x44 returns 0x22222222.
- Misalignment:
  - Stimulus: `st` @0x41, `sth` @0x43, `ldd` @0x44.
  - Response: each gives MFC=1 and MisAlign=1. Memory and DataOut are unchanged.
- Handshake and latency:
  - Stimulus: W=0 and W=3; MFA held high 5 extra cycles; MFA dropped during WAIT1.
  - Response: MFC latency is W+1. MFC stays high until MFA=0. A dropped MFA still completes the op with MFC high for at least 1 cycle.
- Reset during `std`:
  - Stimulus: assert reset in WAIT2.
  - Response: outputs go to 0 immediately. Word 0 @base is written; word 1 @base+4 is unchanged.
